paddle_ctrl: RTL and testbench

Consumes the debounced up/down button levels and owns one paddle's vertical position for the pong game. Position updates once per video frame on a frame-tick strobe. Position is clamped to the playfield. The output feeds the renderer and the ball-collision logic.

---
 rtl/pong_pkg.sv | 34 +++
 rtl/speed_ramp.sv | 51 +++++
 rtl/paddle_ctrl.sv | 83 ++++++++
 tb/tb_paddle_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong constants, paddle FSM state type and position step helpers.
// Used by the paddle, renderer and ball-collision blocks.
package pong_pkg;

    localparam int SCREEN_H = 480;
    localparam int PADDLE_H = 64;
    localparam int Y_W      = 10;
    localparam int Y_MAX    = SCREEN_H - PADDLE_H;
    localparam int Y_INIT   = Y_MAX / 2;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN
    } paddle_state_t;

    function automatic logic [Y_W-1:0] y_step_up(
        input logic [Y_W-1:0] y,
        input logic [Y_W-1:0] step
    );
        return (y < step) ? '0 : y - step;
    endfunction

    // One extra bit keeps y+step from wrapping before the clamp.
    function automatic logic [Y_W-1:0] y_step_down(
        input logic [Y_W-1:0] y,
        input logic [Y_W-1:0] step
    );
        logic [Y_W:0] sum;
        sum = {1'b0, y} + {1'b0, step};
        return (sum > (Y_W+1)'(Y_MAX)) ? Y_W'(Y_MAX) : sum[Y_W-1:0];
    endfunction

endpackage

// File: rtl/speed_ramp.sv
// Paddle step ramp: counts held-direction frames and raises the step,
// saturating at MAX_SPEED. Only built when PADDLE_ACCEL_EN is defined.
module speed_ramp
    import pong_pkg::*;
#(
    parameter int SPEED        = 4,
    parameter int ACCEL_FRAMES = 8,
    parameter int MAX_SPEED    = 12
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic           same_dir,
    input  logic           restart,
    output logic [Y_W-1:0] speed
);

    localparam int CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

    logic [Y_W-1:0]   speed_q;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] cnt_eff;
    logic [Y_W:0]     bumped;

    // A restarting tick already moves at the base step and counts as frame 0.
    assign speed   = restart ? Y_W'(SPEED) : speed_q;
    assign cnt_eff = restart ? '0 : hold_cnt;
    assign bumped  = {1'b0, speed} + (Y_W+1)'(SPEED);

    always_ff @(posedge clk) begin
        if (reset) begin
            speed_q  <= Y_W'(SPEED);
            hold_cnt <= '0;
        end else if (tick) begin
            if (!same_dir) begin
                speed_q  <= Y_W'(SPEED);
                hold_cnt <= '0;
            end else if (cnt_eff == CNT_W'(ACCEL_FRAMES - 1)) begin
                hold_cnt <= '0;
                if (bumped > (Y_W+1)'(MAX_SPEED))
                    speed_q <= Y_W'(MAX_SPEED);
                else
                    speed_q <= bumped[Y_W-1:0];
            end else begin
                hold_cnt <= cnt_eff + 1'b1;
                speed_q  <= speed;
            end
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// One pong paddle: per-frame up/down movement clamped to the playfield.
// Define PADDLE_ACCEL_EN to ramp the step while a direction is held.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int SPEED        = 4,
    parameter int ACCEL_FRAMES = 8,
    parameter int MAX_SPEED    = 12
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           frame_tick,
    input  logic           btn_up,
    input  logic           btn_down,
    output logic [Y_W-1:0] paddle_y,
    output logic           moving,
    output logic           at_top,
    output logic           at_bottom
);

    paddle_state_t  state;
    paddle_state_t  state_nx;
    logic [Y_W-1:0] step;
    logic [Y_W-1:0] y_nx;

    always_comb begin
        state_nx = IDLE;
        unique case (1'b1)
            (btn_up & ~btn_down): state_nx = MOVE_UP;
            (btn_down & ~btn_up): state_nx = MOVE_DOWN;
            default:              state_nx = IDLE;
        endcase
    end

`ifdef PADDLE_ACCEL_EN
    logic same_dir;
    logic restart;

    // Going idle or changing direction drops back to the base step.
    assign same_dir = (state_nx != IDLE);
    assign restart  = (state_nx != state) || (state_nx == IDLE);

    speed_ramp #(
        .SPEED       (SPEED),
        .ACCEL_FRAMES(ACCEL_FRAMES),
        .MAX_SPEED   (MAX_SPEED)
    ) u_ramp (
        .clk     (clk),
        .reset   (reset),
        .tick    (frame_tick),
        .same_dir(same_dir),
        .restart (restart),
        .speed   (step)
    );
`else
    assign step = Y_W'(SPEED);
`endif

    always_comb begin
        y_nx = paddle_y;
        case (state_nx)
            MOVE_UP:   y_nx = y_step_up(paddle_y, step);
            MOVE_DOWN: y_nx = y_step_down(paddle_y, step);
            default:   y_nx = paddle_y;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            paddle_y <= Y_W'(Y_INIT);
            moving   <= 1'b0;
        end else if (frame_tick) begin
            state    <= state_nx;
            paddle_y <= y_nx;
            moving   <= (y_nx != paddle_y);
        end
    end

    assign at_top    = (paddle_y == '0);
    assign at_bottom = (paddle_y == Y_W'(Y_MAX));

endmodule

// File: tb/tb_paddle_ctrl.sv
// Scoreboard bench for paddle_ctrl; expectations queued at each tick.
// Accel-only scenarios are enabled with PADDLE_ACCEL_EN.
module tb_paddle_ctrl;

    localparam int SPEED     = 4;
    localparam int ACCEL_FR  = 8;
    localparam int MAX_SPEED = 12;
    localparam int Y_MAX     = 416;
    localparam int Y_INIT    = 208;

    typedef struct {
        int y;
        int mv;
        int top;
        int bot;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [9:0] paddle_y;
    logic       moving;
    logic       at_top;
    logic       at_bottom;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    int m_y   = Y_INIT;
    int m_st  = 0;
    int m_spd = SPEED;
    int m_cnt = 0;

    paddle_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .paddle_y  (paddle_y),
        .moving    (moving),
        .at_top    (at_top),
        .at_bottom (at_bottom)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_exp(input int y, input int mv);
        exp_t e;
        e.y   = y;
        e.mv  = mv;
        e.top = (y == 0) ? 1 : 0;
        e.bot = (y == Y_MAX) ? 1 : 0;
        return e;
    endfunction

    // Reference model of one frame tick, built from the paddle rules.
    task automatic model_tick(input bit up, input bit dn);
        int ns, spd, cnt, ny;
        bit rst;
        ns  = (up && !dn) ? 1 : (dn && !up) ? 2 : 0;
        rst = (ns != m_st) || (ns == 0);
        spd = rst ? SPEED : m_spd;
        cnt = rst ? 0 : m_cnt;
`ifndef PADDLE_ACCEL_EN
        spd = SPEED;
`endif
        ny = m_y;
        if (ns == 1) ny = (m_y < spd) ? 0 : m_y - spd;
        if (ns == 2) ny = (m_y + spd > Y_MAX) ? Y_MAX : m_y + spd;
        if (ns == 0) begin
            m_spd = SPEED;
            m_cnt = 0;
        end else if (cnt == ACCEL_FR - 1) begin
            m_cnt = 0;
            m_spd = (spd + SPEED > MAX_SPEED) ? MAX_SPEED : spd + SPEED;
        end else begin
            m_cnt = cnt + 1;
            m_spd = spd;
        end
        sb.push_back(mk_exp(ny, (ny != m_y) ? 1 : 0));
        m_y  = ny;
        m_st = ns;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_y"}, paddle_y, e.y);
            check({tag, "_mv"}, moving, e.mv);
            check({tag, "_top"}, at_top, e.top);
            check({tag, "_bot"}, at_bottom, e.bot);
        end
    endtask

    task automatic tick(input bit up, input bit dn, input string tag);
        @(negedge clk);
        btn_up     = up;
        btn_down   = dn;
        frame_tick = 1'b1;
        model_tick(up, dn);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        pop_check(tag);
    endtask

    task automatic do_reset(input bit with_tick, input bit up);
        @(negedge clk);
        reset      = 1'b1;
        frame_tick = with_tick;
        btn_up     = up;
        btn_down   = 1'b0;
        m_y   = Y_INIT;
        m_st  = 0;
        m_spd = SPEED;
        m_cnt = 0;
        sb.push_back(mk_exp(Y_INIT, 0));
        @(posedge clk);
        #1;
        reset      = 1'b0;
        frame_tick = 1'b0;
        btn_up     = 1'b0;
        pop_check("rst");
    endtask

    initial begin
        repeat (2) @(posedge clk);
        do_reset(1'b0, 1'b0);

        for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, "t1");
        check("t1_y", paddle_y, 208);
        check("t1_top", at_top, 0);
        check("t1_bot", at_bottom, 0);

`ifndef PADDLE_ACCEL_EN
        for (int k = 1; k <= 60; k++) begin
            tick(1'b0, 1'b1, "t2");
            if (k == 52) begin
                check("t2_y52", paddle_y, 416);
                check("t2_bot52", at_bottom, 1);
            end
            if (k > 52) check("t2_wall_mv", moving, 0);
        end
        check("t2_end", paddle_y, 416);

        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 52; k++) tick(1'b1, 1'b0, "t3");
        check("t3_y", paddle_y, 0);
        check("t3_top", at_top, 1);
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b1, "t3b");
        check("t3_both_y", paddle_y, 0);
        check("t3_both_mv", moving, 0);
`else
        for (int k = 1; k <= 26; k++) begin
            tick(1'b0, 1'b1, "t4");
            if (k == 8)  check("t4_y8", paddle_y, 240);
            if (k == 16) check("t4_y16", paddle_y, 304);
            if (k == 25) check("t4_y25", paddle_y, 412);
            if (k == 26) check("t4_y26", paddle_y, 416);
        end
        for (int k = 0; k < 10; k++) tick(1'b1, 1'b0, "t4u");
        check("t4_up10", paddle_y, 368);
        tick(1'b0, 1'b0, "t4r");
        tick(1'b1, 1'b0, "t4p");
        check("t4_base_step", paddle_y, 364);

        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 12; k++) tick(1'b1, 1'b0, "t5");
        check("t5_up12", paddle_y, 144);
        tick(1'b0, 1'b1, "t5rev");
        check("t5_rev", paddle_y, 148);
`endif

        do_reset(1'b0, 1'b0);
`ifndef PADDLE_ACCEL_EN
        for (int k = 0; k < 27; k++) tick(1'b1, 1'b0, "t6");
`else
        for (int k = 0; k < 17; k++) tick(1'b1, 1'b0, "t6");
`endif
        check("t6_y100", paddle_y, 100);
        check("t6_mv", moving, 1);
        do_reset(1'b1, 1'b1);
        check("t6_rst_y", paddle_y, 208);
        check("t6_rst_mv", moving, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            btn_up   = k[0];
            btn_down = ~k[0];
            @(posedge clk);
            #1;
            check("t6_gap_y", paddle_y, 208);
        end
        tick(1'b0, 1'b0, "t6end");
        check("t6_end_y", paddle_y, 208);
        check("sb_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
